// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle for the sequential restoring divider.
// The master issues operands; the slave (divider) returns the registered result and flags.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic [2*WIDTH-1:0]     result;
    logic                   div_by_zero;
    logic                   overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, result, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, result, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider (one quotient bit per clock, fixed WIDTH+1 cycle latency).
// Define DIVIDER_SIGNED_EN for two's-complement division; the default build is unsigned.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      count_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   dvsr_r;
    logic [WIDTH-1:0]   divd_raw_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               ovf_pend_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;
    logic               div_by_zero_r;
    logic               overflow_r;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [WIDTH-1:0]   quo_next_s;

    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

`ifdef DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        if (x[WIDTH-1] == 1'b1) begin
            return neg_val(x);
        end else begin
            return x;
        end
    endfunction
`endif

    // One restoring step: shift {R,Q} left and keep the trial difference when it is non-negative.
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvsr_r};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_next_s = trial_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM, iteration datapath and registered result/flag outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            count_r       <= {CW{1'b0}};
            rem_r         <= {WIDTH{1'b0}};
            quo_r         <= {WIDTH{1'b0}};
            dvsr_r        <= {WIDTH{1'b0}};
            divd_raw_r    <= {WIDTH{1'b0}};
            neg_q_r       <= 1'b0;
            neg_r_r       <= 1'b0;
            ovf_pend_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            quotient_r    <= {WIDTH{1'b0}};
            remainder_r   <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r       <= ST_RUN;
                        busy_r        <= 1'b1;
                        count_r       <= CW'(WIDTH);
                        rem_r         <= {WIDTH{1'b0}};
                        divd_raw_r    <= bus.dividend;
                        div_by_zero_r <= 1'b0;
                        overflow_r    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                        quo_r      <= abs_val(bus.dividend);
                        dvsr_r     <= abs_val(bus.divisor);
                        neg_q_r    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_r_r    <= bus.dividend[WIDTH-1];
                        ovf_pend_r <= (bus.dividend == MIN_VAL) && (bus.divisor == {WIDTH{1'b1}});
`else
                        quo_r      <= bus.dividend;
                        dvsr_r     <= bus.divisor;
                        neg_q_r    <= 1'b0;
                        neg_r_r    <= 1'b0;
                        ovf_pend_r <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (count_r == {CW{1'b0}}) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        if (dvsr_r == {WIDTH{1'b0}}) begin
                            // Divide-by-zero: iteration result is discarded in favour of fixed values.
                            quotient_r    <= {WIDTH{1'b1}};
                            remainder_r   <= divd_raw_r;
                            div_by_zero_r <= 1'b1;
                            overflow_r    <= 1'b0;
                        end else begin
                            quotient_r    <= neg_q_r ? neg_val(quo_r) : quo_r;
                            remainder_r   <= neg_r_r ? neg_val(rem_r) : rem_r;
                            div_by_zero_r <= 1'b0;
                            overflow_r    <= ovf_pend_r;
                        end
                    end else begin
                        rem_r   <= rem_next_s;
                        quo_r   <= quo_next_s;
                        count_r <= count_r - CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.result      = {remainder_r, quotient_r};
    assign bus.div_by_zero = div_by_zero_r;
    assign bus.overflow    = overflow_r;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed vectors push expectations,
// a monitor pops and checks them whenever done is presented.
module tb_seq_restoring_divider;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   done_count;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           due;
        string        name;
    } exp_t;

    exp_t sb[$];

    seq_restoring_divider_if #(.WIDTH(W)) dif ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dif.done === 1'b1) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_latency"}, cyc, e.due);
                chk({e.name, "_q"}, dif.quotient, e.q);
                chk({e.name, "_r"}, dif.remainder, e.r);
                chk({e.name, "_result"}, dif.result, {e.r, e.q});
                chk({e.name, "_dbz"}, dif.div_by_zero, e.dbz);
                chk({e.name, "_ovf"}, dif.overflow, e.ovf);
                chk({e.name, "_busy_low"}, dif.busy, 1'b0);
            end
        end
    end

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(posedge clk);
        #1;
        acc       = cyc;
        dif.start = 1'b0;
    endtask

    task automatic issue(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input logic eovf, output int acc);
        exp_t e;
        go(a, b, acc);
        e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf; e.due = acc + 9; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", {31'd0, ok}, 32'd1);
        sb.delete();
    endtask

    initial begin
        int acc;
        int dc;
        cyc        = 0;
        n_checks   = 0;
        n_fail     = 0;
        done_count = 0;
        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {dif.busy, dif.done, dif.div_by_zero, dif.overflow, dif.result},
            32'd0);
        rst = 1'b0;

        // T1: 100/7 with busy tracked cycle by cycle
        issue("t1", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, acc);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t1_busy", {dif.busy, dif.done}, 2'b10);
        end
        drain();
        chk("t1_result_held", dif.result, 16'h020E);

        // T2: divide by zero
        issue("t2", 8'd25, 8'd0, 8'hFF, 8'h19, 1'b1, 1'b0, acc);
        drain();

        // Unsigned-only boundaries / signed-only corner cases
`ifdef DIVIDER_SIGNED_EN
        issue("t3a", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, acc);
        drain();
        issue("t3b", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, acc);
        drain();
        issue("t3c", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, acc);
        drain();
        issue("t3d", 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1, 1'b0, acc);
        drain();
`else
        issue("u_max1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0, acc);
        drain();
        issue("u_small", 8'd7, 8'd9, 8'd0, 8'd7, 1'b0, 1'b0, acc);
        drain();
        issue("u_maxmax", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0, acc);
        drain();
        issue("u_msb", 8'd128, 8'd255, 8'd0, 8'd128, 1'b0, 1'b0, acc);
        drain();
`endif

        // T4: start pulses while busy are ignored
        dc = done_count;
        issue("t4", 8'd200, 8'd10, 8'd20, 8'd0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dif.start    = (i == 2 || i == 4);
            dif.dividend = 8'd9;
            dif.divisor  = 8'd3;
        end
        @(negedge clk);
        dif.start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        chk("t4_single_done", done_count - dc, 32'd1);

        // T5: back-to-back with start held through done; flags must clear
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 8'd25;
        dif.divisor  = 8'd0;
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.q = 8'hFF; e.r = 8'h19; e.dbz = 1'b1; e.ovf = 1'b0; e.due = cyc + 9; e.name = "t5a";
            sb.push_back(e);
        end
        dif.dividend = 8'd50;
        dif.divisor  = 8'd5;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (dif.done === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("t5_first_done_seen", {31'd0, seen}, 32'd1);
        end
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.q = 8'd10; e.r = 8'd0; e.dbz = 1'b0; e.ovf = 1'b0; e.due = cyc + 9; e.name = "t5b";
            sb.push_back(e);
        end
        dif.start = 1'b0;
        @(negedge clk);
        chk("t5_flags_cleared", {dif.busy, dif.div_by_zero, dif.overflow}, 3'b100);
        drain();

        // T6: reset mid-division aborts silently
        dc = done_count;
        go(8'd255, 8'd3, acc);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_reset_outputs", {dif.busy, dif.done, dif.div_by_zero, dif.overflow, dif.result},
            32'd0);
        repeat (12) @(negedge clk);
        chk("t6_no_done", done_count - dc, 32'd0);
        issue("t6_after", 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 1'b0, acc);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
